// File: rtl/instruction_decode.sv
// Decode stage of the 5-stage RV32I-subset pipeline: IF/ID latch, decoder,
// write-first register file and ID/EX latch with load-use stall and flush bubbles.
module instruction_decode #(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_in,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rd_out,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        branch,
    output logic        branch_ne,
    output logic        jump,
    output logic        illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLL    = 4'd6;
    localparam logic [3:0] ALU_SRL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_PASS_B = 4'd9;

    logic        vld_p0;
    logic [31:0] instr_p0;
    logic [31:0] pc_p0;
    logic [31:0] regs [0:31];

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       f7_zero;
    logic       f7_alt;

    assign opcode  = instr_p0[6:0];
    assign rd      = instr_p0[11:7];
    assign funct3  = instr_p0[14:12];
    assign rs1     = instr_p0[19:15];
    assign rs2     = instr_p0[24:20];
    assign funct7  = instr_p0[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_u;

    assign imm_i = {{20{instr_p0[31]}}, instr_p0[31:20]};
    assign imm_s = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
    assign imm_b = {{20{instr_p0[31]}}, instr_p0[7], instr_p0[30:25], instr_p0[11:8], 1'b0};
    assign imm_j = {{12{instr_p0[31]}}, instr_p0[19:12], instr_p0[20], instr_p0[30:21], 1'b0};
    assign imm_u = {instr_p0[31:12], 12'b0};

    logic [3:0]  d_alu_op;
    logic        d_alu_src;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_reg_write;
    logic        d_branch;
    logic        d_branch_ne;
    logic        d_jump;
    logic        d_illegal;
    logic [31:0] d_imm;
    logic [4:0]  d_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        bad;

    always_comb begin
        d_alu_op    = ALU_ADD;
        d_alu_src   = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_branch_ne = 1'b0;
        d_jump      = 1'b0;
        d_illegal   = 1'b0;
        d_imm       = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        bad         = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                d_reg_write = 1'b1;
                case (funct3)
                    3'b000: begin d_alu_op = f7_alt ? ALU_SUB : ALU_ADD; bad = !(f7_zero || f7_alt); end
                    3'b001: begin d_alu_op = ALU_SLL; bad = !f7_zero; end
                    3'b010: begin d_alu_op = ALU_SLT; bad = !f7_zero; end
                    3'b100: begin d_alu_op = ALU_XOR; bad = !f7_zero; end
                    3'b101: begin d_alu_op = f7_alt ? ALU_SRA : ALU_SRL; bad = !(f7_zero || f7_alt); end
                    3'b110: begin d_alu_op = ALU_OR;  bad = !f7_zero; end
                    3'b111: begin d_alu_op = ALU_AND; bad = !f7_zero; end
                    default: bad = 1'b1;
                endcase
            end
            OP_I: begin
                use_rs1     = 1'b1;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm       = imm_i;
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin d_alu_op = ALU_SLL; bad = !f7_zero; end
                    3'b101: begin d_alu_op = f7_alt ? ALU_SRA : ALU_SRL; bad = !(f7_zero || f7_alt); end
                    default: bad = 1'b1;
                endcase
            end
            OP_LW: begin
                use_rs1     = 1'b1;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm       = imm_i;
                bad         = (funct3 != 3'b010);
            end
            OP_SW: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_imm       = imm_s;
                bad         = (funct3 != 3'b010);
            end
            OP_BR: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                d_branch    = 1'b1;
                d_branch_ne = funct3[0];
                d_alu_op    = ALU_SUB;
                d_imm       = imm_b;
                bad         = (funct3[2:1] != 2'b00);
            end
            OP_JAL: begin
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_j;
            end
            OP_LUI: begin
                d_alu_op    = ALU_PASS_B;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                d_imm       = imm_u;
            end
            default: bad = 1'b1;
        endcase
        // An unsupported encoding must not drive any datapath action downstream
        if (bad) begin
            d_alu_op    = ALU_ADD;
            d_alu_src   = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_reg_write = 1'b0;
            d_branch    = 1'b0;
            d_branch_ne = 1'b0;
            d_jump      = 1'b0;
            d_imm       = '0;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
            d_illegal   = 1'b1;
        end
        // rd bits of stores/branches are immediate bits, so only real destinations are passed on
        d_rd = d_reg_write ? rd : 5'd0;
    end

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
    end

    always_ff @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end

    assign stall = vld_p0 && valid_out && mem_read && (rd_out != 5'd0) &&
                   ((use_rs1 && rd_out == rs1) || (use_rs2 && rd_out == rs2));

    // IF/ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            instr_p0 <= NOP;
            pc_p0    <= '0;
        end else if (flush) begin
            vld_p0   <= 1'b0;
            instr_p0 <= NOP;
        end else if (!stall) begin
            vld_p0   <= 1'b1;
            instr_p0 <= instruction;
            pc_p0    <= pc_in;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk) begin
        if (rst || flush || stall || !vld_p0) begin
            valid_out <= 1'b0;
            pc_out    <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            imm       <= '0;
            rd_out    <= '0;
            alu_op    <= '0;
            alu_src   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            branch    <= 1'b0;
            branch_ne <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            valid_out <= 1'b1;
            pc_out    <= pc_p0;
            rs1_data  <= rs1_val;
            rs2_data  <= rs2_val;
            imm       <= d_imm;
            rd_out    <= d_rd;
            alu_op    <= d_alu_op;
            alu_src   <= d_alu_src;
            mem_read  <= d_mem_read;
            mem_write <= d_mem_write;
            reg_write <= d_reg_write;
            branch    <= d_branch;
            branch_ne <= d_branch_ne;
            jump      <= d_jump;
            illegal   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed instructions push hand-computed
// ID/EX contents into a queue; a negedge monitor pops and compares on valid_out.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_out;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        illegal;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instruction_decode #(.NOP(NOP)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_in(pc_in), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .valid_out(valid_out), .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .rd_out(rd_out), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch(branch), .branch_ne(branch_ne), .jump(jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] im;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [7:0]  fl;
    } dec_t;

    // flag order: alu_src, mem_read, mem_write, reg_write, branch, branch_ne, jump, illegal
    localparam logic [7:0] SRC = 8'h80, MR = 8'h40, MW = 8'h20, RW = 8'h10;
    localparam logic [7:0] BR  = 8'h08, BNE = 8'h04, JMP = 8'h02, ILL = 8'h01;

    dec_t act;
    assign act = {pc_out, rs1_data, rs2_data, imm, rd_out, alu_op,
                  alu_src, mem_read, mem_write, reg_write, branch, branch_ne, jump, illegal};

    dec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic dec_t mk(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [4:0] rd, input logic [3:0] op,
                                input logic [7:0] fl);
        mk = {pc, r1, r2, im, rd, op, fl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic chk_dec(input string name, input dec_t got, input dec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input dec_t e);
        instruction = ins;
        pc_in       = pc;
        chk("no_stall", 32'(stall), 32'd0);
        exp_q.push_back(e);
        step();
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", act);
            end else begin
                dec_t e;
                e = exp_q.pop_front();
                chk_dec("decode", act, e);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; instruction = 32'h00500093; pc_in = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // reset held while preloading xN = {4{N}}
        for (int i = 1; i < 32; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = {4{8'(i)}};
            step();
            if (i == 2) begin
                chk_dec("reset_outputs", act, '0);
                chk("reset_stall", 32'(stall), 32'd0);
            end
        end
        wb_en = 1'b0;
        rst   = 1'b0;

        issue(32'h00500093, 32'h10, mk(32'h10, 32'h0, 32'h05050505, 32'd5, 5'd1, 4'd0, SRC | RW));
        issue(32'h0000A103, 32'h14, mk(32'h14, 32'h01010101, 32'h0, 32'h0, 5'd2, 4'd0, SRC | MR | RW));
        issue(32'h002101B3, 32'h18, mk(32'h18, 32'h02020202, 32'h02020202, 32'h0, 5'd3, 4'd0, RW));

        instruction = 32'h010000EF; pc_in = 32'h1C;
        chk("load_use_stall", 32'(stall), 32'd1);
        step();
        chk("bubble_valid", 32'(valid_out), 32'd0);
        chk("stall_released", 32'(stall), 32'd0);
        exp_q.push_back(mk(32'h1C, 32'h0, 32'h10101010, 32'h10, 5'd1, 4'd0, JMP | RW));
        step();

        issue(32'h12345237, 32'h20, mk(32'h20, 32'h08080808, 32'h03030303, 32'h12345000, 5'd4, 4'd9, SRC | RW));
        issue(32'h4043D493, 32'h24, mk(32'h24, 32'h07070707, 32'h04040404, 32'h00000404, 5'd9, 4'd8, SRC | RW));
        issue(32'h0070A423, 32'h28, mk(32'h28, 32'h01010101, 32'h07070707, 32'h8, 5'd0, 4'd0, SRC | MW));
        issue(32'hFE209CE3, 32'h2C, mk(32'h2C, 32'h01010101, 32'h02020202, 32'hFFFFFFF8, 5'd0, 4'd1, BR | BNE));
        issue(32'h40028333, 32'h30, mk(32'h30, 32'hDEADBEEF, 32'h0, 32'h0, 5'd6, 4'd1, RW));

        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        issue(32'h0000007F, 32'h34, mk(32'h34, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, ILL));
        wb_en = 1'b0;
        issue(32'h0020B1B3, 32'h38, mk(32'h38, 32'h01010101, 32'h02020202, 32'h0, 5'd0, 4'd0, ILL));

        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h00001234;
        issue(32'h00000533, 32'h3C, mk(32'h3C, 32'h0, 32'h0, 32'h0, 5'd10, 4'd0, RW));
        issue(32'h0000A103, 32'h40, mk(32'h40, 32'h01010101, 32'h0, 32'h0, 5'd2, 4'd0, SRC | MR | RW));
        wb_en = 1'b0;

        instruction = 32'h002101B3; pc_in = 32'h44;
        chk("no_stall_pre_flush", 32'(stall), 32'd0);
        step();
        chk("stall_before_flush", 32'(stall), 32'd1);
        flush = 1'b1; instruction = 32'h00500093; pc_in = 32'h48;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_ifid_instr", dut.instr_p0, NOP);
        chk("flush_ifid_valid", 32'(dut.vld_p0), 32'd0);

        issue(32'h00500093, 32'h80, mk(32'h80, 32'h0, 32'hDEADBEEF, 32'd5, 5'd1, 4'd0, SRC | RW));

        instruction = 32'h0000A103; pc_in = 32'h84;
        step();
        rst = 1'b1; instruction = 32'h00500093; pc_in = 32'h88;
        step();
        rst = 1'b0;
        chk_dec("midreset_outputs", act, '0);
        chk("midreset_stall", 32'(stall), 32'd0);
        chk("midreset_ifid_valid", 32'(dut.vld_p0), 32'd0);

        issue(32'h00500093, 32'h100, mk(32'h100, 32'h0, 32'hDEADBEEF, 32'd5, 5'd1, 4'd0, SRC | RW));

        instruction = NOP; pc_in = 32'h104;
        step();
        flush = 1'b1;
        step();
        step();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
